// File: rtl/mem_access_if.sv
// Single-port data-memory bus between the memory-access stage (master) and data memory (slave).
// Request/acknowledge handshake; the master holds the request fields stable until DMemAck.
interface mem_access_if;
  logic        DMemReq;
  logic        DMemWe;
  logic [63:0] DMemAddr;
  logic [63:0] DMemWData;
  logic [7:0]  DMemWMask;
  logic [63:0] DMemRData;
  logic        DMemAck;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemWData, DMemWMask,
    input  DMemRData, DMemAck
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemWMask,
    output DMemRData, DMemAck
  );
endinterface

// File: rtl/mem_access.sv
// RV64I memory-access stage: issues aligned loads/stores on the data-memory bus, extends load
// data, and registers the write-back bundle. Misaligned accesses are dropped with a pulse.
module mem_access (
  input  logic                Clk,
  input  logic                Rst_n,
  mem_access_if.master        bus,
  input  logic                ValidIn,
  input  logic [6:0]          OpCodeIn,
  input  logic [2:0]          Funct3In,
  input  logic [63:0]         ImmIn,
  input  logic [63:0]         Rs1ReadDataIn,
  input  logic [63:0]         Rs2ReadDataIn,
  input  logic [63:0]         RdWriteDataIn,
  input  logic [4:0]          RdAddrIn,
  input  logic                RdWriteEnableIn,
  output logic                StallOut,
  output logic                ValidOut,
  output logic [63:0]         RdWriteDataOut,
  output logic [4:0]          RdAddrOut,
  output logic                RdWriteEnableOut,
  output logic                MisalignOut
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [0:0] {StIdle, StBusy} stateT;

  stateT       stateQ, stateD;
  logic        weQ, weD;
  logic [63:0] addrQ, addrD;
  logic [63:0] wDataQ, wDataD;
  logic [7:0]  wMaskQ, wMaskD;
  logic [1:0]  sizeQ, sizeD;
  logic        unsignedQ, unsignedD;
  logic [2:0]  offQ, offD;
  logic [4:0]  rdAddrQ, rdAddrD;
  logic        rdWeQ, rdWeD;

  logic        validOutQ, validOutD;
  logic [63:0] rdDataOutQ, rdDataOutD;
  logic [4:0]  rdAddrOutQ, rdAddrOutD;
  logic        rdWeOutQ, rdWeOutD;
  logic        misalignQ, misalignD;

  logic [63:0] effAddr;
  logic [2:0]  off;
  logic        isLoad, isStore, memOp, misaligned, startAccess, dropAccess;
  logic [7:0]  sizeMask;
  logic [63:0] loadShift, loadData;
  logic        stall;

  // Decode and alignment of the instruction offered by execute.
  always_comb begin
    effAddr = Rs1ReadDataIn + ImmIn;
    off     = effAddr[2:0];
    isLoad  = (OpCodeIn == OpLoad) && (Funct3In != 3'b111);
    isStore = (OpCodeIn == OpStore) && !Funct3In[2];
    unique case (Funct3In[1:0])
      2'd0:    begin misaligned = 1'b0;        sizeMask = 8'h01; end
      2'd1:    begin misaligned = off[0];      sizeMask = 8'h03; end
      2'd2:    begin misaligned = |off[1:0];   sizeMask = 8'h0F; end
      default: begin misaligned = |off;        sizeMask = 8'hFF; end
    endcase
    memOp       = ValidIn && (isLoad || isStore);
    startAccess = memOp && !misaligned;
    dropAccess  = memOp && misaligned;
  end

  // Load extraction uses the offset and size captured at issue, not the live inputs.
  always_comb begin
    loadShift = bus.DMemRData >> {offQ, 3'b000};
    unique case (sizeQ)
      2'd0:    loadData = {{56{~unsignedQ & loadShift[7]}},  loadShift[7:0]};
      2'd1:    loadData = {{48{~unsignedQ & loadShift[15]}}, loadShift[15:0]};
      2'd2:    loadData = {{32{~unsignedQ & loadShift[31]}}, loadShift[31:0]};
      default: loadData = loadShift;
    endcase
  end

  always_comb begin
    stateD     = stateQ;
    weD        = weQ;
    addrD      = addrQ;
    wDataD     = wDataQ;
    wMaskD     = wMaskQ;
    sizeD      = sizeQ;
    unsignedD  = unsignedQ;
    offD       = offQ;
    rdAddrD    = rdAddrQ;
    rdWeD      = rdWeQ;
    validOutD  = 1'b0;
    rdDataOutD = '0;
    rdAddrOutD = '0;
    rdWeOutD   = 1'b0;
    misalignD  = 1'b0;
    stall      = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (startAccess) begin
          stateD    = StBusy;
          stall     = 1'b1;
          weD       = isStore;
          addrD     = {effAddr[63:3], 3'b000};
          wDataD    = isStore ? (Rs2ReadDataIn << {off, 3'b000}) : '0;
          wMaskD    = isStore ? (sizeMask << off) : '0;
          sizeD     = Funct3In[1:0];
          unsignedD = Funct3In[2];
          offD      = off;
          rdAddrD   = RdAddrIn;
          rdWeD     = isLoad && RdWriteEnableIn;
        end else if (dropAccess) begin
          validOutD  = 1'b1;
          misalignD  = 1'b1;
          rdAddrOutD = RdAddrIn;
        end else if (ValidIn) begin
          validOutD  = 1'b1;
          rdDataOutD = RdWriteDataIn;
          rdAddrOutD = RdAddrIn;
          rdWeOutD   = RdWriteEnableIn;
        end
      end
      StBusy: begin
        stall = ~bus.DMemAck;
        if (bus.DMemAck) begin
          stateD     = StIdle;
          weD        = 1'b0;
          addrD      = '0;
          wDataD     = '0;
          wMaskD     = '0;
          validOutD  = 1'b1;
          rdDataOutD = weQ ? '0 : loadData;
          rdAddrOutD = rdAddrQ;
          rdWeOutD   = rdWeQ;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ     <= StIdle;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wDataQ     <= '0;
      wMaskQ     <= '0;
      sizeQ      <= '0;
      unsignedQ  <= 1'b0;
      offQ       <= '0;
      rdAddrQ    <= '0;
      rdWeQ      <= 1'b0;
      validOutQ  <= 1'b0;
      rdDataOutQ <= '0;
      rdAddrOutQ <= '0;
      rdWeOutQ   <= 1'b0;
      misalignQ  <= 1'b0;
    end else begin
      stateQ     <= stateD;
      weQ        <= weD;
      addrQ      <= addrD;
      wDataQ     <= wDataD;
      wMaskQ     <= wMaskD;
      sizeQ      <= sizeD;
      unsignedQ  <= unsignedD;
      offQ       <= offD;
      rdAddrQ    <= rdAddrD;
      rdWeQ      <= rdWeD;
      validOutQ  <= validOutD;
      rdDataOutQ <= rdDataOutD;
      rdAddrOutQ <= rdAddrOutD;
      rdWeOutQ   <= rdWeOutD;
      misalignQ  <= misalignD;
    end
  end

  assign bus.DMemReq   = (stateQ == StBusy);
  assign bus.DMemWe    = weQ;
  assign bus.DMemAddr  = addrQ;
  assign bus.DMemWData = wDataQ;
  assign bus.DMemWMask = wMaskQ;

  assign StallOut         = stall;
  assign ValidOut         = validOutQ;
  assign RdWriteDataOut   = rdDataOutQ;
  assign RdAddrOut        = rdAddrOutQ;
  assign RdWriteEnableOut = rdWeOutQ;
  assign MisalignOut      = misalignQ;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a behavioural model of effective address, alignment,
// store lanes and load extension predicts every bus field and write-back result.
module tb_mem_access;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAdd   = 7'b0110011;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ValidIn = 1'b0;
  logic [6:0]  OpCodeIn = '0;
  logic [2:0]  Funct3In = '0;
  logic [63:0] ImmIn = '0, Rs1ReadDataIn = '0, Rs2ReadDataIn = '0, RdWriteDataIn = '0;
  logic [4:0]  RdAddrIn = '0;
  logic        RdWriteEnableIn = 1'b0;
  logic        StallOut, ValidOut, RdWriteEnableOut, MisalignOut;
  logic [63:0] RdWriteDataOut;
  logic [4:0]  RdAddrOut;

  int nTotal = 0;
  int nBad = 0;

  mem_access_if bus ();

  always #5 Clk = ~Clk;

  mem_access dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .bus              (bus),
    .ValidIn          (ValidIn),
    .OpCodeIn         (OpCodeIn),
    .Funct3In         (Funct3In),
    .ImmIn            (ImmIn),
    .Rs1ReadDataIn    (Rs1ReadDataIn),
    .Rs2ReadDataIn    (Rs2ReadDataIn),
    .RdWriteDataIn    (RdWriteDataIn),
    .RdAddrIn         (RdAddrIn),
    .RdWriteEnableIn  (RdWriteEnableIn),
    .StallOut         (StallOut),
    .ValidOut         (ValidOut),
    .RdWriteDataOut   (RdWriteDataOut),
    .RdAddrOut        (RdAddrOut),
    .RdWriteEnableOut (RdWriteEnableOut),
    .MisalignOut      (MisalignOut)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] loadModel(input logic [63:0] rdata, input int unsigned offI,
                                            input logic [2:0] f3);
    int unsigned nBytes;
    logic [63:0] v, lim;
    nBytes = 1 << f3[1:0];
    v = rdata >> (8 * offI);
    if (nBytes == 8) return v;
    lim = 64'd1 << (8 * nBytes);
    v = v % lim;
    if (!f3[2] && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".req"},   bus.DMemReq,      0);
    checkVal({tag, ".we"},    bus.DMemWe,       0);
    checkVal({tag, ".addr"},  bus.DMemAddr,     0);
    checkVal({tag, ".wdata"}, bus.DMemWData,    0);
    checkVal({tag, ".wmask"}, bus.DMemWMask,    0);
    checkVal({tag, ".stall"}, StallOut,         0);
    checkVal({tag, ".valid"}, ValidOut,         0);
    checkVal({tag, ".rdata"}, RdWriteDataOut,   0);
    checkVal({tag, ".rd"},    RdAddrOut,        0);
    checkVal({tag, ".rdwe"},  RdWriteEnableOut, 0);
    checkVal({tag, ".mis"},   MisalignOut,      0);
  endtask

  // Called at a falling edge; returns at a falling edge with the result visible.
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] rs1,
                          input logic [63:0] imm, input logic [63:0] rs2, input logic [63:0] rdw,
                          input logic [4:0] rd, input logic we, input int delay,
                          input logic [63:0] rdata);
    logic [63:0] ea;
    int unsigned offI, nBytes, stalls;
    logic isLd, isSt, mis;
    logic [15:0] maskWide;
    ea     = rs1 + imm;
    offI   = int'(ea[2:0]);
    nBytes = 1 << f3[1:0];
    isLd   = (op == OpLoad) && (f3 != 3'b111);
    isSt   = (op == OpStore) && (f3 < 3'd4);
    mis    = (isLd || isSt) && ((offI % nBytes) != 0);
    maskWide = ((16'd1 << nBytes) - 16'd1) << offI;
    ValidIn = 1'b1; OpCodeIn = op; Funct3In = f3; ImmIn = imm; Rs1ReadDataIn = rs1;
    Rs2ReadDataIn = rs2; RdWriteDataIn = rdw; RdAddrIn = rd; RdWriteEnableIn = we;
    bus.DMemAck = 1'b0;
    #1;
    if ((isLd || isSt) && !mis) begin
      stalls = (StallOut === 1'b1) ? 1 : 0;
      @(posedge Clk); @(negedge Clk);
      for (int d = 0; d <= delay; d++) begin
        checkVal("busReq",  bus.DMemReq,  1);
        checkVal("busAddr", bus.DMemAddr, {ea[63:3], 3'b000});
        checkVal("busWe",   bus.DMemWe,   isSt);
        if (isSt) begin
          checkVal("busWData", bus.DMemWData, rs2 << (8 * offI));
          checkVal("busWMask", bus.DMemWMask, maskWide[7:0]);
        end
        checkVal("busyValid", ValidOut, 0);
        if (d == delay) begin
          bus.DMemAck = 1'b1;
          bus.DMemRData = rdata;
        end
        #1;
        if (StallOut === 1'b1) stalls++;
        @(posedge Clk); @(negedge Clk);
      end
      bus.DMemAck = 1'b0;
      bus.DMemRData = {$urandom, $urandom};
      checkVal("stallCycles", stalls, delay + 1);
      checkVal("doneValid", ValidOut, 1);
      checkVal("doneMis", MisalignOut, 0);
      checkVal("doneReqLow", bus.DMemReq, 0);
      checkVal("doneAddrIdle", bus.DMemAddr, 0);
      checkVal("doneRdWe", RdWriteEnableOut, isLd && we);
      if (isLd) begin
        checkVal("loadData", RdWriteDataOut, loadModel(rdata, offI, f3));
        checkVal("loadRd", RdAddrOut, rd);
      end
    end else begin
      checkVal("noStall", StallOut, 0);
      @(posedge Clk); @(negedge Clk);
      checkVal("oneCycReq", bus.DMemReq, 0);
      checkVal("oneCycValid", ValidOut, 1);
      checkVal("oneCycMis", MisalignOut, mis);
      if (mis) begin
        checkVal("misRdWe", RdWriteEnableOut, 0);
      end else begin
        checkVal("passData", RdWriteDataOut, rdw);
        checkVal("passRd", RdAddrOut, rd);
        checkVal("passWe", RdWriteEnableOut, we);
      end
    end
  endtask

  // An acknowledge strobe while idle must not produce anything.
  task automatic idleCycle(input logic ackNoise);
    ValidIn = 1'b0;
    bus.DMemAck = ackNoise;
    #1;
    checkVal("idleStall", StallOut, 0);
    @(posedge Clk); @(negedge Clk);
    bus.DMemAck = 1'b0;
    checkVal("idleValid", ValidOut, 0);
    checkVal("idleReq", bus.DMemReq, 0);
  endtask

  initial begin
    bus.DMemAck = 1'b0;
    bus.DMemRData = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checkResetOutputs("postReset");

    // LB sign-extends byte 3.
    runInstr(OpLoad, 3'b000, 64'h1000, 64'd3, 0, 0, 5'd7, 1'b1, 1, 64'h0000_0000_8012_3456);
    checkVal("lbResult", RdWriteDataOut, 64'hFFFF_FFFF_FFFF_FF80);
    // SH into the top halfword lane.
    runInstr(OpStore, 3'b001, 64'h2000, 64'd6, 64'h1234, 0, 5'd0, 1'b1, 0, 0);
    checkVal("shRdWe", RdWriteEnableOut, 0);
    // LWU with a slow acknowledge.
    runInstr(OpLoad, 3'b110, 64'h3000, 64'd4, 0, 0, 5'd9, 1'b1, 3, 64'hDEAD_BEEF_0000_0000);
    checkVal("lwuResult", RdWriteDataOut, 64'h0000_0000_DEAD_BEEF);
    // Misaligned LD is dropped.
    runInstr(OpLoad, 3'b011, 64'h4000, 64'd4, 0, 0, 5'd3, 1'b1, 0, 0);
    checkVal("ldMisPulse", MisalignOut, 1);
    // Pass-through then SD back to back.
    runInstr(OpAdd, 3'b000, 0, 0, 0, 64'h55, 5'd5, 1'b1, 0, 0);
    checkVal("addData", RdWriteDataOut, 64'h55);
    runInstr(OpStore, 3'b011, 64'h5000, 64'd8, 64'h0123_4567_89AB_CDEF, 0, 5'd0, 1'b0, 1, 0);
    idleCycle(1'b1);

    // Reset in the second busy cycle abandons the access.
    ValidIn = 1'b1; OpCodeIn = OpLoad; Funct3In = 3'b011; ImmIn = 0;
    Rs1ReadDataIn = 64'h6000; RdAddrIn = 5'd4; RdWriteEnableIn = 1'b1;
    @(posedge Clk); @(negedge Clk);
    ValidIn = 1'b0;
    @(posedge Clk); @(negedge Clk);
    checkVal("preRstReq", bus.DMemReq, 1);
    #2 Rst_n = 1'b0;
    #1 checkVal("asyncReqDrop", bus.DMemReq, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    bus.DMemAck = 1'b1;
    bus.DMemRData = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge Clk); @(negedge Clk);
    bus.DMemAck = 1'b0;
    checkResetOutputs("lateAck");

    for (int i = 0; i < 250; i++) begin
      int unsigned kind;
      logic [63:0] imm;
      kind = $urandom_range(0, 4);
      imm = 64'($signed({1'b0, 5'($urandom_range(0, 31))}) - 16);
      case (kind)
        0, 1: runInstr(OpLoad, 3'($urandom_range(0, 7)), {$urandom, $urandom}, imm, 0,
                       {$urandom, $urandom}, 5'($urandom), 1'($urandom), $urandom_range(0, 3),
                       {$urandom, $urandom});
        2:    runInstr(OpStore, 3'($urandom_range(0, 7)), {$urandom, $urandom}, imm,
                       {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                       $urandom_range(0, 3), 0);
        3:    runInstr(OpAdd, 3'($urandom), {$urandom, $urandom}, imm, 0, {$urandom, $urandom},
                       5'($urandom), 1'($urandom), 0, 0);
        default: idleCycle(1'($urandom));
      endcase
    end
    idleCycle(1'b0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
